// File: rtl/tlul_sram_responder.sv
// tlul_sram_responder: TL-UL manager serving Get/PutFull/PutPartial from a word-addressed internal memory.
// Ports: clock/reset (sync, active-high); A channel a_valid/a_ready/a_opcode/a_param/a_size/a_source/a_address/a_mask/a_data;
// D channel d_valid/d_ready/d_opcode/d_param/d_size/d_source/d_sink/d_denied/d_data/d_corrupt.
// Optional macro TLUL_SRAM_RESPONDER_DENY_EN: deny out-of-range or unsupported requests instead of wrapping/acking.
module tlul_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int DEPTH = 256,
  parameter int SOURCE_W = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [31:0] mem [DEPTH];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic a_fire, is_get, is_put, denied, unused;
  assign d_valid = state == RESP;
  assign a_ready = !d_valid | d_ready;
  assign a_fire = a_valid & a_ready;
  assign off = a_address - BASE_ADDR;
  assign idx = off[AW+1:2];
  assign is_get = a_opcode == 3'd4;
  assign is_put = a_opcode[2:1] == 2'b00;
`ifdef TLUL_SRAM_RESPONDER_DENY_EN
  assign denied = (off >= 32'(DEPTH * 4)) | !(is_get | is_put);
`else
  assign denied = 1'b0;
`endif
  assign d_param = '0;
  assign d_sink = 1'b0;
  assign unused = ^{a_param, off};
  always_ff @(posedge clock)
    if (!reset && a_fire && is_put && !denied)
      for (int i = 0; i < 4; i++)
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      d_opcode <= '0;
      d_size <= '0;
      d_source <= '0;
      d_data <= '0;
      d_denied <= 1'b0;
      d_corrupt <= 1'b0;
    end else if (a_fire) begin
      state <= RESP;
      d_opcode <= is_get ? 3'd1 : 3'd0;
      d_size <= a_size;
      d_source <= a_source;
      d_data <= (is_get && !denied) ? mem[idx] : '0;
      d_denied <= denied;
      d_corrupt <= denied & is_get;
    end else if (d_ready) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_tlul_sram_responder.sv
// tb_tlul_sram_responder: directed table, hand sequences and random traffic against a queue-based reference model.
module tb_tlul_sram_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 256;
  logic clock, reset, a_valid, a_ready, d_valid, d_ready, d_sink, d_denied, d_corrupt;
  logic [2:0] a_opcode, a_param, d_opcode;
  logic [1:0] a_size, d_size, d_param;
  logic [0:0] a_source, d_source;
  logic [31:0] a_address, a_data, d_data;
  logic [3:0] a_mask;
  int n_cmp = 0, n_bad = 0, rsp_cnt = 0;
  logic lat_due = 0;
  logic [31:0] ref_mem [DEPTH];
  typedef struct {
    logic [2:0] op;
    logic [1:0] size;
    logic src;
    logic [31:0] data;
    logic den;
    logic cor;
  } rsp_t;
  rsp_t q[$];
  typedef struct {
    logic [2:0] op;
    logic [31:0] off;
    logic [3:0] mask;
    logic [31:0] data;
    logic src;
    logic [2:0] e_op;
    logic [31:0] e_data;
    logic e_den;
  } vec_t;
  vec_t tbl[13];

  tlul_sram_responder dut (
    .clock(clock), .reset(reset), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_param(a_param), .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
    .d_corrupt(d_corrupt)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      lat_due = 0;
    end else begin
      if (lat_due) chk("latency_d_valid", {31'd0, d_valid}, 1);
      lat_due = 0;
      chk("a_ready_rule", {31'd0, a_ready}, {31'd0, !d_valid || d_ready});
      if (d_valid) begin
        chk("rsp_pending", {31'd0, q.size() != 0}, 1);
        chk("d_param_sink", {29'd0, d_param, d_sink}, 0);
        if (q.size() != 0) begin
          chk("d_opcode", {29'd0, d_opcode}, {29'd0, q[0].op});
          chk("d_size", {30'd0, d_size}, {30'd0, q[0].size});
          chk("d_source", {31'd0, d_source}, {31'd0, q[0].src});
          chk("d_data", d_data, q[0].data);
          chk("d_denied_corrupt", {30'd0, d_denied, d_corrupt}, {30'd0, q[0].den, q[0].cor});
          if (d_ready) begin
            void'(q.pop_front());
            rsp_cnt++;
          end
        end
      end
      if (a_valid && a_ready) begin
        logic [31:0] off;
        int idx;
        logic sup, den;
        rsp_t r;
        off = a_address - BASE;
        idx = int'((off >> 2) % DEPTH);
        sup = a_opcode inside {3'd0, 3'd1, 3'd4};
`ifdef TLUL_SRAM_RESPONDER_DENY_EN
        den = (off >= 32'(DEPTH * 4)) || !sup;
`else
        den = 1'b0;
`endif
        r.op = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
        r.size = a_size;
        r.src = a_source[0];
        r.data = (a_opcode == 3'd4 && !den) ? ref_mem[idx] : 32'd0;
        r.den = den;
        r.cor = den && a_opcode == 3'd4;
        if (a_opcode inside {3'd0, 3'd1} && !den)
          for (int b = 0; b < 4; b++)
            if (a_mask[b]) ref_mem[idx][8*b +: 8] = a_data[8*b +: 8];
        q.push_back(r);
        lat_due = 1;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] m,
                      input logic [31:0] dt, input logic s, output int tries);
    logic fired;
    a_valid = 1; a_opcode = op; a_address = addr; a_mask = m; a_data = dt; a_source = s; a_size = 2;
    fired = 0;
    tries = 0;
    while (!fired && tries < 64) begin
      @(negedge clock);
      fired = a_ready;
      tries++;
      @(posedge clock);
      #1;
    end
    chk("a_fire_timeout", {31'd0, fired}, 1);
    a_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, c0;
    logic [31:0] wrap_exp;
    tbl[0]  = '{3'd0, 32'h10,  4'hF, 32'hDEADBEEF, 1'b1, 3'd0, 32'h0, 1'b0};
    tbl[1]  = '{3'd4, 32'h10,  4'hF, 32'h0,        1'b1, 3'd1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{3'd0, 32'h20,  4'hF, 32'hAABBCCDD, 1'b0, 3'd0, 32'h0, 1'b0};
    tbl[3]  = '{3'd1, 32'h20,  4'h5, 32'h11223344, 1'b0, 3'd0, 32'h0, 1'b0};
    tbl[4]  = '{3'd4, 32'h20,  4'h0, 32'h0,        1'b1, 3'd1, 32'hAA22CC44, 1'b0};
    tbl[5]  = '{3'd1, 32'h20,  4'h0, 32'hFFFFFFFF, 1'b0, 3'd0, 32'h0, 1'b0};
    tbl[6]  = '{3'd4, 32'h20,  4'hF, 32'h0,        1'b0, 3'd1, 32'hAA22CC44, 1'b0};
    tbl[7]  = '{3'd4, 32'h23,  4'hF, 32'h0,        1'b1, 3'd1, 32'hAA22CC44, 1'b0};
`ifdef TLUL_SRAM_RESPONDER_DENY_EN
    tbl[8]  = '{3'd2, 32'h20,  4'hF, 32'h0,        1'b0, 3'd0, 32'h0, 1'b1};
    wrap_exp = 32'h0;
`else
    tbl[8]  = '{3'd2, 32'h20,  4'hF, 32'h0,        1'b0, 3'd0, 32'h0, 1'b0};
    wrap_exp = init_val(0);
`endif
    tbl[9]  = '{3'd4, 32'h20,  4'hF, 32'h0,        1'b0, 3'd1, 32'hAA22CC44, 1'b0};
    tbl[10] = '{3'd0, 32'h3FC, 4'hF, 32'h12345678, 1'b1, 3'd0, 32'h0, 1'b0};
`ifdef TLUL_SRAM_RESPONDER_DENY_EN
    tbl[11] = '{3'd4, 32'h400, 4'hF, 32'h0,        1'b0, 3'd1, wrap_exp, 1'b1};
`else
    tbl[11] = '{3'd4, 32'h400, 4'hF, 32'h0,        1'b0, 3'd1, wrap_exp, 1'b0};
`endif
    tbl[12] = '{3'd4, 32'h3FC, 4'hF, 32'h0,        1'b1, 3'd1, 32'h12345678, 1'b0};

    reset = 1; a_valid = 0; d_ready = 1; a_opcode = 0; a_param = 0; a_size = 0;
    a_source = 0; a_address = 0; a_mask = 0; a_data = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_d_valid", {31'd0, d_valid}, 0);
    chk("rst_a_ready", {31'd0, a_ready}, 1);
    chk("rst_d_fields", {d_opcode, d_size, d_source, d_denied, d_corrupt}, 0);
    chk("rst_d_data", d_data, 0);
    @(posedge clock);
    #1;

    for (int i = 0; i < DEPTH; i++) send(3'd0, BASE + 32'(i * 4), 4'hF, init_val(i), 1'b0, t);

    for (int i = 0; i < 13; i++) begin
      send(tbl[i].op, BASE + tbl[i].off, tbl[i].mask, tbl[i].data, tbl[i].src, t);
      @(negedge clock);
      chk($sformatf("vec%0d_d_valid", i), {31'd0, d_valid}, 1);
      chk($sformatf("vec%0d_d_opcode", i), {29'd0, d_opcode}, {29'd0, tbl[i].e_op});
      chk($sformatf("vec%0d_d_data", i), d_data, tbl[i].e_data);
      chk($sformatf("vec%0d_d_source", i), {31'd0, d_source}, {31'd0, tbl[i].src});
      chk($sformatf("vec%0d_den_cor", i), {30'd0, d_denied, d_corrupt},
          {30'd0, tbl[i].e_den, tbl[i].e_den && tbl[i].e_op == 3'd1});
      @(posedge clock);
      #1;
    end

    c0 = rsp_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) send(3'd0, BASE + 32'h80 + 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i), 1'b0, t);
      else send(3'd4, BASE + 32'h80 + 32'((i - 8) * 4), 4'hF, 32'h0, 1'b1, t);
      chk("burst_first_try", t, 1);
    end
    @(negedge clock);
    @(posedge clock);
    #1;
    chk("burst_rsp_cnt", rsp_cnt - c0, 16);

    d_ready = 0;
    send(3'd4, BASE + 32'h10, 4'hF, 32'h0, 1'b0, t);
    a_valid = 1; a_opcode = 3'd4; a_address = BASE + 32'h20; a_source = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_a_ready", {31'd0, a_ready}, 0);
      chk("bp_d_valid", {31'd0, d_valid}, 1);
      chk("bp_d_data", d_data, 32'hDEADBEEF);
      @(posedge clock);
      #1;
    end
    d_ready = 1;
    @(negedge clock);
    chk("bp_both_fire", {30'd0, a_ready, d_valid}, 3);
    @(posedge clock);
    #1 a_valid = 0;
    @(negedge clock);
    chk("bp_next_valid", {31'd0, d_valid}, 1);
    chk("bp_next_data", d_data, 32'hAA22CC44);
    @(posedge clock);
    #1;

    d_ready = 0;
    send(3'd4, BASE + 32'h10, 4'hF, 32'h0, 1'b0, t);
    reset = 1;
    a_valid = 1; a_opcode = 3'd0; a_address = BASE + 32'h40; a_mask = 4'hF; a_data = 32'h0BADF00D;
    @(posedge clock);
    #1 reset = 0; a_valid = 0; d_ready = 1;
    @(negedge clock);
    chk("rst_mid_d_valid", {31'd0, d_valid}, 0);
    repeat (3) @(posedge clock);
    #1;
    send(3'd4, BASE + 32'h40, 4'hF, 32'h0, 1'b0, t);
    @(negedge clock);
    chk("rst_no_write", d_data, init_val(16));
    @(posedge clock);
    #1;

    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a_valid = $urandom_range(0, 3) != 0;
      a_opcode = r < 4 ? 3'd4 : r < 7 ? 3'd0 : r < 9 ? 3'd1 : (r[0] ? 3'd2 : 3'd5);
      r = int'($urandom_range(0, 19));
      a_address = r == 0 ? BASE + 32'h400 + $urandom_range(0, 4095) :
                  r == 1 ? BASE - 32'd4 : BASE + {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
      a_mask = 4'($urandom);
      a_data = $urandom;
      a_source = 1'($urandom);
      a_size = 2'($urandom_range(0, 2));
      d_ready = $urandom_range(0, 3) != 0;
      @(posedge clock);
      #1;
    end
    a_valid = 0;
    d_ready = 1;
    for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clock);
    #1;
    chk("drain_empty", q.size(), 0);
    @(negedge clock);
    chk("drain_idle", {31'd0, d_valid}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlul_sram_responder.md
Name: tlul_sram_responder

Overview:
- TileLink-UL responder (manager end) for a 32-bit A/D channel bundle.
- Sinks A-channel requests (Get, PutFullData, PutPartialData) from an initiator or pass-through link.
- Services each request against an internal word-addressed register-file memory and returns exactly one D-channel response per accepted request.
- Used as a scratchpad or debug-RAM target behind the core's TL-UL port.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be aligned to DEPTH*4.
- DEPTH, 256, number of 32-bit words; power of two, 2..4096.
- SOURCE_W, 1, width of a_source / d_source.

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request accepted when a_valid & a_ready
- a_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get; others unsupported
- a_param  in  3  ignored
- a_size  in  2  log2 bytes, 0..2
- a_source  in  SOURCE_W  request tag
- a_address  in  32  byte address
- a_mask  in  4  byte-lane enables
- a_data  in  32  write data
- d_valid  out  1  response valid
- d_ready  in  1  response accepted when d_valid & d_ready
- d_opcode  out  3  0 AccessAck, 1 AccessAckData
- d_param  out  2  always 0
- d_size  out  2  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_sink  out  1  always 0
- d_denied  out  1  error flag (see Optional Feature)
- d_data  out  32  read data; 0 for AccessAck
- d_corrupt  out  1  1 only when d_denied on AccessAckData

Behaviour:
- Reset values:
  - d_valid=0; d_opcode, d_size, d_source, d_data, d_denied, d_corrupt all 0.
  - a_ready=1 in the cycle after reset deasserts.
  - Memory contents are not reset.
- Single-entry response register.
  - a_ready = !d_valid | d_ready (combinational; the entry can be refilled in the same cycle it drains).
  - No combinational path from a_valid to d_valid.
- Latency: request fires at edge N -> d_valid=1 with response fields from edge N (visible cycle N+1).
  - d_valid holds, and all D fields are stable, until d_ready.
  - Sustained throughput: 1 request/cycle while d_ready=1.
- States:
  - IDLE (d_valid=0).
  - RESP (d_valid=1).
  - IDLE->RESP on A fire.
  - RESP->IDLE on D fire without A fire.
  - RESP->RESP on simultaneous D fire and A fire.
- Word index:
  - idx = (a_address - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
  - a_address[1:0] is ignored for indexing; lanes are chosen by a_mask.
- Get:
  - d_opcode=1, d_data = mem[idx], captured at fire.
  - All 32 bits are returned regardless of mask.
- PutFull/PutPartial:
  - For each i with a_mask[i]=1: mem[idx][8i+7:8i] <= a_data[8i+7:8i].
  - d_opcode=0, d_data=0.
  - mask=4'b0000 writes nothing but still acks.
- Unsupported opcode: d_opcode=0 (AccessAck), no memory effect.
- Ordering:
  - A Put at edge N followed by a Get to the same idx at edge N+1 returns the new data.
  - Responses are strictly in request order.
- Reset mid-operation: a pending response is discarded (d_valid=0 next cycle); no memory write occurs for a request presented in a reset cycle.

Optional Feature:
- Macro TLUL_SRAM_RESPONDER_DENY_EN.
- Defined:
  - The range check is (a_address - BASE_ADDR) < DEPTH*4 as an unsigned 32-bit compare.
  - A request is denied if it is out of range or has an unsupported opcode.
  - A denied request performs no write and returns d_denied=1.
  - A denied Get returns d_opcode=1, d_data=0, d_corrupt=1.
- Undefined:
  - The address wraps modulo DEPTH words.
  - d_denied and d_corrupt are tied to 0.
  - Unsupported opcodes get a plain AccessAck.

Test Plan:
- Reset, then Get at BASE_ADDR+0x10 after PutFull data 32'hDEADBEEF mask 4'hF, source 1 -> Put ack d_opcode=0 d_source=1; Get d_opcode=1 d_data=32'hDEADBEEF, each one cycle after fire.
- PutPartial mask 4'b0101 data 32'h11223344 over word 32'hAABBCCDD, then Get -> d_data=32'hAA22CC44.
- Back-to-back 8 Puts then 8 Gets with d_ready=1 constantly -> a_ready never drops, 16 responses in consecutive cycles, data matches.
- d_ready held 0 for 5 cycles with a_valid=1 -> a_ready=0, D fields stable; on d_ready=1 both fire the same cycle and the next response follows one cycle later.
- With DENY_EN: Get at BASE_ADDR+DEPTH*4 -> d_denied=1, d_corrupt=1, d_data=0. Without DENY_EN: the same Get returns the mem[0] contents.
- reset asserted while d_valid=1 -> d_valid=0 next cycle, no stale response after reset release.
